// File: rtl/renkon_conv_wbuf_if.sv
// Weight-stream / active-tap bundle for renkon_conv_wbuf.
// The bias signal exists only when RENKON_WBUF_BIAS_EN is defined.
interface renkon_conv_wbuf_if #(
    parameter int DWIDTH = 16,
    parameter int FSIZE  = 5
);
    localparam int N = FSIZE * FSIZE;

    logic                wreg_clr;
    logic                wreg_we;
    logic [DWIDTH-1:0]   read_weight;
    logic                swap;
    logic                load_done;
    logic                active_valid;
    logic [DWIDTH*N-1:0] weight;
`ifdef RENKON_WBUF_BIAS_EN
    logic [DWIDTH-1:0]   bias;

    modport master (
        output wreg_clr, wreg_we, read_weight, swap,
        input  load_done, active_valid, weight, bias
    );
    modport slave (
        input  wreg_clr, wreg_we, read_weight, swap,
        output load_done, active_valid, weight, bias
    );
`else
    modport master (
        output wreg_clr, wreg_we, read_weight, swap,
        input  load_done, active_valid, weight
    );
    modport slave (
        input  wreg_clr, wreg_we, read_weight, swap,
        output load_done, active_valid, weight
    );
`endif
endinterface

// File: rtl/renkon_conv_wbuf.sv
// Double-buffered conv weight buffer: serial shadow load, one-cycle swap to the active bank.
// Optional bias word (load length N+1) enabled by the RENKON_WBUF_BIAS_EN macro.
module renkon_conv_wbuf #(
    parameter int DWIDTH = 16,
    parameter int FSIZE  = 5
) (
    input  logic              clk,
    input  logic              xrst,
    renkon_conv_wbuf_if.slave wbuf
);
    localparam int N = FSIZE * FSIZE;
`ifdef RENKON_WBUF_BIAS_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nxt_s;
    logic                accept_s;
    logic                xfer_s;
    logic                shift_s;
    logic                load_done_nxt_s;
    logic                load_done_r;
    logic                active_valid_r;
    logic [DWIDTH-1:0]   shadow_r [N];
    logic [DWIDTH*N-1:0] weight_r;
`ifdef RENKON_WBUF_BIAS_EN
    logic [CW-1:0]       pos_s;
    logic                bias_cap_s;
    logic [DWIDTH-1:0]   shadow_bias_r;
    logic [DWIDTH-1:0]   bias_r;
`endif

    // State and load-count register.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_r <= ST_EMPTY;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next count/state: clear beats swap beats write; swap in FULL may start the next set.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        state_nxt_s = state_r;
        if (wbuf.wreg_clr) begin
            cnt_nxt_s = '0;
        end else if (wbuf.swap && (state_r == ST_FULL)) begin
            cnt_nxt_s = wbuf.wreg_we ? CW'(1) : '0;
        end else if (wbuf.wreg_we && (state_r != ST_FULL)) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end

        if (cnt_nxt_s == '0) begin
            state_nxt_s = ST_EMPTY;
        end else if (cnt_nxt_s == CW'(L)) begin
            state_nxt_s = ST_FULL;
        end else begin
            state_nxt_s = ST_LOAD;
        end
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        xfer_s   = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            ST_EMPTY, ST_LOAD: begin
                xfer_s   = 1'b0;
                accept_s = wbuf.wreg_we && !wbuf.wreg_clr;
            end
            ST_FULL: begin
                xfer_s   = wbuf.swap && !wbuf.wreg_clr;
                accept_s = wbuf.swap && !wbuf.wreg_clr && wbuf.wreg_we;
            end
            default: begin
                xfer_s   = 1'b0;
                accept_s = 1'b0;
            end
        endcase
        load_done_nxt_s = (state_nxt_s == ST_FULL);
    end

`ifdef RENKON_WBUF_BIAS_EN
    // Word slot within the set; a word accepted alongside a swap is slot 0 of the next set.
    always_comb begin
        pos_s      = (state_r == ST_FULL) ? '0 : cnt_r;
        shift_s    = accept_s && (pos_s < CW'(N));
        bias_cap_s = accept_s && (pos_s == CW'(N));
    end
`else
    // Every accepted word goes into the tap shift chain.
    always_comb begin
        shift_s = accept_s;
    end
`endif

    // Shadow tap shift chain: oldest word ends at tap 0.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int k = 0; k < N; k++) begin
                shadow_r[k] <= '0;
            end
        end else if (shift_s) begin
            for (int k = 0; k < N - 1; k++) begin
                shadow_r[k] <= shadow_r[k + 1];
            end
            shadow_r[N - 1] <= wbuf.read_weight;
        end
    end

    // Active bank captures the pre-shift shadow on a qualifying swap.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            weight_r <= '0;
        end else if (xfer_s) begin
            for (int k = 0; k < N; k++) begin
                weight_r[DWIDTH*k +: DWIDTH] <= shadow_r[k];
            end
        end
    end

`ifdef RENKON_WBUF_BIAS_EN
    // Shadow and active bias registers.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            shadow_bias_r <= '0;
            bias_r        <= '0;
        end else begin
            if (bias_cap_s) begin
                shadow_bias_r <= wbuf.read_weight;
            end
            if (xfer_s) begin
                bias_r <= shadow_bias_r;
            end
        end
    end

    assign wbuf.bias = bias_r;
`endif

    // Registered status flags.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            load_done_r    <= 1'b0;
            active_valid_r <= 1'b0;
        end else begin
            load_done_r <= load_done_nxt_s;
            if (xfer_s) begin
                active_valid_r <= 1'b1;
            end
        end
    end

    assign wbuf.load_done    = load_done_r;
    assign wbuf.active_valid = active_valid_r;
    assign wbuf.weight       = weight_r;

endmodule

// File: doc/renkon_conv_wbuf.md
# renkon_conv_wbuf

Parametrised, double-buffered convolution weight buffer: the next generation of the 5x5 conv weight register. A serial weight stream fills a shadow bank of FSIZE*FSIZE taps while the active bank drives the convolution array. A swap handshake then moves the shadow bank into the active bank in one cycle, so weight loading overlaps computation. Sits between the weight memory read port and the conv core's parallel weight inputs.

## Interface

Parameters:
- DWIDTH, 16, weight word width (signed two's complement)
- FSIZE, 5, filter edge; tap count N = FSIZE*FSIZE

Ports:
- clk  in  1  rising-edge clock
- xrst  in  1  asynchronous, active-low reset
- wreg_clr  in  1  abort/restart the current shadow load
- wreg_we  in  1  accept read_weight into the shadow bank this cycle
- read_weight  in  DWIDTH  signed weight word
- swap  in  1  request shadow-to-active transfer
- load_done  out  1  shadow bank holds a complete set
- active_valid  out  1  active bank has been loaded at least once since reset
- weight  out  DWIDTH*N  active taps, flattened; tap k at [DWIDTH*(k+1)-1:DWIDTH*k]
- bias  out  DWIDTH  active bias (only with RENKON_WBUF_BIAS_EN)

## Operation

- Load length L = N, or N+1 with the bias option.
- Load counter cnt has width $clog2(L+1) and never exceeds L.
- FSM states: EMPTY (cnt=0), LOAD (0<cnt<L), FULL (cnt=L).
- Shadow shift on an accepted wreg_we:
  - Each shadow tap k takes tap k+1; tap N-1 takes read_weight; cnt increments.
  - After N writes, the first word written sits at tap 0 and the last at tap N-1.
- wreg_we is accepted in EMPTY and LOAD. In FULL it is ignored: no shift, no count.
- Transition to FULL when cnt reaches L. load_done = (state == FULL).
- swap in FULL:
  - The active bank (and bias) takes the shadow contents on that edge.
  - active_valid is set; cnt returns to 0; state goes to EMPTY.
- swap outside FULL is ignored: no state change and no error.
- swap together with wreg_we in FULL:
  - Transfer happens; the active bank captures the pre-shift shadow value.
  - The word is accepted as the first of the next set: cnt=1, state LOAD.
- wreg_clr sets cnt=0 and state EMPTY. Shadow data is not cleared. The active bank, bias and active_valid are unaffected.
- Priority: wreg_clr over swap over wreg_we. With wreg_clr and swap together, no transfer occurs.
- No arithmetic on data: words are stored bit-exact and sign is preserved.

## Timing

- Reset (xrst=0, asynchronous):
  - All shadow and active taps, bias and cnt are 0; state is EMPTY.
  - load_done=0, active_valid=0, weight=0, bias=0.
- Outputs are registered, with no combinational path from any input to any output.
- load_done rises on the edge that accepts the L-th word and is visible the next cycle.
- weight/bias change exactly one cycle after a qualifying swap, and at no other time.
- load_done falls in the cycle after the swap or wreg_clr edge.
- Minimum load time: L consecutive wreg_we cycles. Back-to-back sets are sustainable at one word per cycle with one swap per L cycles (swap coincident with the next set's first word).
- Gaps in wreg_we are allowed; the count holds.
- Reset asserted mid-load or mid-swap discards everything and returns to the reset state immediately.

## Configuration

- Macro: RENKON_WBUF_BIAS_EN.
- Defined:
  - L = N+1; the (N+1)-th word is captured in a dedicated shadow bias register, not shifted into the taps.
  - The shadow bias register is copied to the bias port on swap.
  - The shadow taps shift only for words 1..N.
- Undefined:
  - L = N; the bias port and bias registers are absent.

## Test plan

- Reset: drive xrst=0 mid-stream, then release -> load_done=0, active_valid=0, all weight taps 0, cnt 0.
- Fill and swap (DWIDTH=16, FSIZE=3): write 1..9, swap -> next cycle tap0=1, tap8=9, active_valid=1, load_done=0.
- Overfill: write 1..9, then 10 and 11 without swap, then swap -> taps still 1..9; words 10 and 11 are dropped.
- Premature swap, then clear:
  - swap after 4 writes -> active bank unchanged.
  - wreg_clr, then write 20..28, swap -> tap0=20, tap8=28.
- Back-to-back: sets A=1..9 and B=-1..-9 streamed continuously, with swap on B's first word -> active shows A; after B completes and is swapped, tap0=-1 (0xFFFF).
- With RENKON_WBUF_BIAS_EN (FSIZE=5): write 1..25 and then 99, swap -> tap24=25, bias=99; after only 25 writes, load_done=0.
